// File: rtl/fdc_sample_decimator.sv
// FDC sample decimator: averages windows of N = 2^(dec_sel+1) unsigned 8-bit
// samples and hands each average downstream over a valid/ready output register.
module fdc_sample_decimator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic [1:0] dec_sel,
  input  logic       clr,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       overrun,
  output logic       busy
);

  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] acc_q, acc_d;
  logic [1:0]  win_sel_q, win_sel_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        overrun_q, overrun_d;

  logic        accept;
  logic        handshake;
  logic        win_done;
  logic [1:0]  cur_sel;
  logic [3:0]  last_idx;
  logic [11:0] sum;
  logic [7:0]  avg;

  // Window accumulation, result formation and output/overrun next-state.
  always_comb begin
    accept    = in_valid & ena & ~clr;
    handshake = out_valid_q & out_ready;
    // The first sample of a window uses the live dec_sel; later ones use the latched copy.
    cur_sel   = (cnt_q == 4'd0) ? dec_sel : win_sel_q;
    sum       = acc_q + {4'd0, in_data};

    last_idx = 4'd1;
    avg      = sum[8:1];
    unique case (cur_sel)
      2'd0: begin last_idx = 4'd1;  avg = sum[8:1];  end
      2'd1: begin last_idx = 4'd3;  avg = sum[9:2];  end
      2'd2: begin last_idx = 4'd7;  avg = sum[10:3]; end
      2'd3: begin last_idx = 4'd15; avg = sum[11:4]; end
      default: ;
    endcase

    win_done = accept & (cnt_q == last_idx);

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    win_sel_d   = win_sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;

    if (clr) begin
      cnt_d     = 4'd0;
      acc_d     = 12'd0;
      overrun_d = 1'b0;
    end else if (accept) begin
      if (cnt_q == 4'd0) win_sel_d = dec_sel;
      if (win_done) begin
        cnt_d = 4'd0;
        acc_d = 12'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
        acc_d = sum;
      end
    end

    // A finished window loads only if the output slot is empty or draining this cycle.
    if (win_done) begin
      if (!out_valid_q || handshake) begin
        out_valid_d = 1'b1;
        out_data_d  = avg;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      acc_q       <= 12'd0;
      win_sel_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      win_sel_q   <= win_sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;
  assign busy      = (cnt_q != 4'd0);

endmodule

// File: tb/tb_fdc_sample_decimator.sv
// Self-checking bench for fdc_sample_decimator: directed scenarios plus a
// randomized run, all compared against a window-average reference model.
module tb_fdc_sample_decimator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] dec_sel;
  logic       clr;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       overrun;
  logic       busy;

  fdc_sample_decimator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .dec_sel   (dec_sel),
    .clr       (clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: samples collected in the current window and the window size.
  int m_cnt   = 0;
  int m_sum   = 0;
  int m_n     = 2;
  bit m_valid = 0;
  int m_data  = 0;
  bit m_ovr   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit hs;
    bit new_res;
    int res;
    hs      = m_valid && out_ready;
    new_res = 0;
    res     = 0;
    if (!rst_n) begin
      m_cnt = 0; m_sum = 0; m_n = 2; m_valid = 0; m_data = 0; m_ovr = 0;
    end else begin
      if (clr) begin
        m_cnt = 0; m_sum = 0; m_ovr = 0;
      end else if (ena && in_valid) begin
        if (m_cnt == 0) m_n = 2 ** (int'(dec_sel) + 1);
        m_sum += int'(in_data);
        m_cnt++;
        if (m_cnt == m_n) begin
          new_res = 1;
          res     = m_sum / m_n;
          m_cnt   = 0;
          m_sum   = 0;
        end
      end
      if (new_res) begin
        if (!m_valid || hs) begin
          m_valid = 1;
          m_data  = res;
        end else begin
          m_ovr = 1;
        end
      end else if (hs) begin
        m_valid = 0;
      end
    end
  endtask

  // Advance one clock with the current inputs and compare all outputs to the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_data", {24'd0, out_data}, m_data);
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    check("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset with random inputs held for two cycles.
    rst_n     = 1'b0;
    ena       = 1'($urandom);
    in_valid  = 1'($urandom);
    in_data   = 8'($urandom);
    dec_sel   = 2'($urandom);
    clr       = 1'($urandom);
    out_ready = 1'($urandom);
    tick();
    in_valid = 1'($urandom);
    in_data  = 8'($urandom);
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);

    rst_n = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = 8'd0;
    clr = 1'b0; out_ready = 1'b0; dec_sel = 2'd1;
    tick();

    // N=4 average of 10,20,30,41.
    send(8'd10); send(8'd20); send(8'd30); send(8'd41);
    check("n4_valid", {31'd0, out_valid}, 32'd1);
    check("n4_data", {24'd0, out_data}, 32'd25);
    drain();
    check("n4_drained", {31'd0, out_valid}, 32'd0);

    // N=16 full-scale window.
    dec_sel = 2'd3;
    for (int i = 0; i < 16; i++) begin
      send(8'd255);
      if (i == 0) check("n16_busy_first", {31'd0, busy}, 32'd1);
    end
    check("n16_data", {24'd0, out_data}, 32'd255);
    check("n16_overrun", {31'd0, overrun}, 32'd0);
    check("n16_busy_last", {31'd0, busy}, 32'd0);
    drain();

    // N=2 overrun while the output is stalled, then drain and clear.
    dec_sel = 2'd0;
    send(8'd4); send(8'd6); send(8'd8); send(8'd10);
    check("ovr_data", {24'd0, out_data}, 32'd5);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    drain();
    check("ovr_drain_valid", {31'd0, out_valid}, 32'd0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Window completes on the same cycle as a handshake.
    send(8'd4); send(8'd6);
    check("hs_pre_data", {24'd0, out_data}, 32'd5);
    send(8'd8);
    out_ready = 1'b1;
    send(8'd10);
    out_ready = 1'b0;
    check("hs_valid", {31'd0, out_valid}, 32'd1);
    check("hs_data", {24'd0, out_data}, 32'd9);
    check("hs_overrun", {31'd0, overrun}, 32'd0);
    drain();

    // Reset mid-window, then a fresh window immune to a mid-window dec_sel change.
    dec_sel = 2'd1;
    send(8'd100); send(8'd100); send(8'd100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    send(8'd8);
    dec_sel = 2'd3;
    send(8'd8); send(8'd8); send(8'd8);
    check("midrst_valid", {31'd0, out_valid}, 32'd1);
    check("midrst_data", {24'd0, out_data}, 32'd8);
    drain();

    // ena=0 ignores samples.
    ena = 1'b0;
    send(8'd77);
    check("ena_off_busy", {31'd0, busy}, 32'd0);
    ena = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(63) != 0);
      clr       = ($urandom_range(31) == 0);
      ena       = ($urandom_range(7) != 0);
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      dec_sel   = 2'($urandom);
      out_ready = 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fdc_sample_decimator.md
FDC_SAMPLE_DECIMATOR -- requirements
Module: fdc_sample_decimator

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL provide: ena  input  1  design enable; when 0, in_valid is ignored.
REQ-004 SHALL provide: in_valid  input  1  one-cycle strobe; in_data holds a new FDC count sample.
REQ-005 SHALL provide: in_data  input  8  unsigned FDC count sample from the upstream FDC core.
REQ-006 SHALL provide: dec_sel  input  2  window size N = 2^(dec_sel+1), giving N in {2,4,8,16}.
REQ-007 SHALL provide: clr  input  1  synchronous soft clear of window and overrun.
REQ-008 SHALL provide: out_ready  input  1  downstream ready.
REQ-009 SHALL provide: out_valid  output  1  averaged result available.
REQ-010 SHALL provide: out_data  output  8  averaged result, held stable while out_valid=1 and out_ready=0.
REQ-011 SHALL provide: overrun  output  1  sticky; set when a completed result was dropped.
REQ-012 SHALL provide: busy  output  1  high while the window holds at least one accepted sample.

Function
REQ-013 SHALL accept a sample when in_valid=1 and ena=1 and clr=0; accumulator width 12 bits (16 x 255 = 4080, no overflow possible).
REQ-014 SHALL latch dec_sel into an internal window register when the first sample of a window is accepted; dec_sel changes mid-window SHALL NOT affect the current window.
REQ-015 SHALL maintain a 4-bit sample counter; on acceptance of sample N, result = accumulator_sum >> (dec_sel_latched+1) (truncating), and counter and accumulator SHALL return to 0 in the same cycle.
REQ-016 SHALL present a completed result at out_valid/out_data on the cycle after the edge that accepted sample N (latency 1).
REQ-017 SHALL use a separate output register, so a new window accumulates while a result waits.
REQ-018 SHALL complete a handshake when out_valid=1 and out_ready=1; out_valid SHALL drop next cycle unless a new result loads in that same cycle.
REQ-019 When a window completes in the same cycle as a handshake, SHALL load the new result, keep out_valid=1, and leave overrun unchanged.
REQ-020 When a window completes while out_valid=1 and out_ready=0, SHALL drop the new result, keep the old out_data, and set overrun=1.
REQ-021 overrun SHALL clear only on reset or clr.
REQ-022 clr=1 SHALL zero counter, accumulator and overrun, and discard any simultaneous sample; it SHALL NOT affect out_valid/out_data.
REQ-023 ena=0 SHALL freeze accumulation only; the output handshake SHALL continue to operate.
REQ-024 busy SHALL equal (counter != 0), registered.

Reset
REQ-025 On a rising clk edge with rst_n=0: out_valid=0, out_data=0, overrun=0, busy=0, counter=0, accumulator=0, latched dec_sel=0; all of these regardless of other inputs.
REQ-026 Reset asserted mid-window SHALL discard partial samples; the first accepted sample after release SHALL start a fresh window.

Verification
REQ-027 Reset: hold rst_n=0 for 2 cycles with random inputs -> out_valid=0, out_data=0, overrun=0, busy=0.
REQ-028 dec_sel=1 (N=4); samples 10,20,30,41 -> one cycle after 4th sample, out_valid=1 and out_data=25 (101>>2).
REQ-029 dec_sel=3 (N=16); 16 samples of 255 -> out_data=255 and overrun=0; busy high after sample 1 and low after sample 16.
REQ-030 dec_sel=0 (N=2); out_ready=0; samples 4,6 then 8,10 -> out_data stays 5 and overrun=1. Then out_ready=1 for one cycle -> out_valid=0 next cycle and overrun stays 1; then clr -> overrun=0.
REQ-031 N=2 with out_valid=1 (out_data=5); samples 8,10 with out_ready=1 on the cycle of sample 10 -> out_valid stays 1, out_data=9, overrun=0.
REQ-032 N=4; 3 samples of 100, then rst_n=0 one cycle, then 4 samples of 8 -> out_data=8; a dec_sel change from 1 to 3 after the first of those samples -> window still closes at 4 samples.
